// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage integer/FP core.
// Produces combinational stall, flush and forwarding controls. A small FSM
// holds the execute stage while a multi-cycle FP ALU op completes.
//
//   state | meaning
//   IDLE  | no multi-cycle FP op in progress (an arriving op stalls here)
//   BUSY  | FP op in execute, cnt = execute cycles already elapsed
module hazard_ctrl #(
    parameter int unsigned FP_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        FPRs1D,
    input  logic        FPRs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic        FPRs1E,
    input  logic        FPRs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        FPDestE,
    input  logic        FPDestM,
    input  logic        FPDestW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        FPAluE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        FPBusy,
    output logic        FPDone,
    output logic [15:0] StallCount
);

    typedef enum logic {IDLE, BUSY} fp_state_t;

    // Final elapsed count of a multi-cycle op; single-cycle ops never enter BUSY.
    localparam logic [3:0] LAST_CNT = 4'(FP_LAT - 1);
    localparam bit         MULTI    = (FP_LAT > 1);

    fp_state_t  state;
    logic [3:0] cnt;
    logic       lw_stall;
    logic       fp_stall;
    logic       fp_done;

    // x0 is hard-wired zero and never a dependency; f0 is a real register.
    function automatic logic reg_match(input logic [4:0] rs, input logic fprs,
                                       input logic [4:0] rd, input logic fprd);
        return (rs == rd) && (fprs == fprd) && (fprd || (rd != 5'd0));
    endfunction

    // Memory-stage result is newer than writeback, so it takes priority.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic fprs);
        if (RegWriteM && reg_match(rs, fprs, RdM, FPDestM))
            return 2'b10;
        else if (RegWriteW && reg_match(rs, fprs, RdW, FPDestW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection: load-use and FP sequencer stall/done decode.
    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) &&
                   (reg_match(Rs1D, FPRs1D, RdE, FPDestE) ||
                    reg_match(Rs2D, FPRs2D, RdE, FPDestE));
        fp_stall = 1'b0;
        fp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (FPAluE) begin
                    if (MULTI) fp_stall = 1'b1;
                    else       fp_done  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == LAST_CNT) fp_done  = 1'b1;
                else                 fp_stall = 1'b1;
            end
            default: begin
                fp_stall = 1'b0;
                fp_done  = 1'b0;
            end
        endcase
    end

    // Output decode; everything is forced quiet while reset is held.
    // fp_stall outranks any coincident load or branch, suppressing FlushE.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        FPBusy    = 1'b0;
        FPDone    = 1'b0;
        if (!reset) begin
            StallF    = lw_stall | fp_stall;
            StallD    = lw_stall | fp_stall;
            StallE    = fp_stall;
            FlushM    = fp_stall;
            FlushD    = PCSrcE;
            FlushE    = (lw_stall | PCSrcE) & ~fp_stall;
            ForwardAE = fwd_sel(Rs1E, FPRs1E);
            ForwardBE = fwd_sel(Rs2E, FPRs2E);
            FPBusy    = (state == BUSY);
            FPDone    = fp_done;
        end
    end

    // FP sequencer: count execute cycles of a multi-cycle op, back to IDLE on the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (FPAluE && MULTI) begin
                        state <= BUSY;
                        cnt   <= 4'd1;
                    end
                end
                BUSY: begin
                    if (cnt == LAST_CNT) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCount <= 16'd0;
        else if (StallF && (StallCount != 16'hFFFF))
            StallCount <= StallCount + 16'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FP_LAT = 4): table of single-cycle
// hazard/forwarding vectors, then hand-written FP sequencing and reset runs.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        FPRs1D, FPRs2D, FPRs1E, FPRs2E;
    logic        FPDestE, FPDestM, FPDestW, RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, FPAluE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        FPBusy, FPDone;
    logic [15:0] StallCount;

    hazard_ctrl #(.FP_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .FPRs1D(FPRs1D), .FPRs2D(FPRs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .FPRs1E(FPRs1E), .FPRs2E(FPRs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .FPDestE(FPDestE), .FPDestM(FPDestM), .FPDestW(FPDestW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .FPAluE(FPAluE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .FPBusy(FPBusy), .FPDone(FPDone), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1d, rs2d;
        logic       fprs1d, fprs2d;
        logic [4:0] rs1e, rs2e;
        logic       fprs1e, fprs2e;
        logic [4:0] rde, rdm, rdw;
        logic       fpde, fpdm, fpdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pcsrc, fpalu;
    } in_t;

    // Bit order: StallF StallD StallE FlushD FlushE FlushM ForwardAE ForwardBE FPBusy FPDone
    typedef struct packed {
        logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
        logic [1:0] fwd_a, fwd_b;
        logic       fp_busy, fp_done;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    vec_t  tbl[$];
    out_t  exp_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;
    int    sc_model = 0;

    localparam logic [11:0] O_NONE  = 12'b000000_00_00_00;
    localparam logic [11:0] O_LW    = 12'b110010_00_00_00;
    localparam logic [11:0] O_FP_ID = 12'b111001_00_00_00;
    localparam logic [11:0] O_FP_BZ = 12'b111001_00_00_10;
    localparam logic [11:0] O_FP_DN = 12'b000000_00_00_11;

    task automatic drive(input in_t i);
        reset      = i.rst;
        Rs1D       = i.rs1d;   Rs2D   = i.rs2d;
        FPRs1D     = i.fprs1d; FPRs2D = i.fprs2d;
        Rs1E       = i.rs1e;   Rs2E   = i.rs2e;
        FPRs1E     = i.fprs1e; FPRs2E = i.fprs2e;
        RdE        = i.rde;    RdM    = i.rdm;    RdW = i.rdw;
        FPDestE    = i.fpde;   FPDestM = i.fpdm;  FPDestW = i.fpdw;
        RegWriteM  = i.rwm;    RegWriteW = i.rww;
        ResultSrcE = i.rsrc;
        PCSrcE     = i.pcsrc;
        FPAluE     = i.fpalu;
    endtask

    // Drive just after a rising edge, compare on the following falling edge.
    task automatic step(input in_t i, input logic [11:0] e, input string nm);
        out_t got, want;
        @(posedge clk);
        #1;
        drive(i);
        exp_q.push_back(out_t'(e));
        @(negedge clk);
        got  = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                ForwardAE, ForwardBE, FPBusy, FPDone};
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s outputs got=%b required=%b", nm, got, want);
        end
        if (i.rst) sc_model = 0;
        n_vec++;
        if (StallCount !== 16'(sc_model)) begin
            n_fail++;
            $display("FAIL %s StallCount got=%0d required=%0d", nm, StallCount, sc_model);
        end
        if (!i.rst && want.stall_f) sc_model++;
    endtask

    task automatic add(input in_t i, input logic [11:0] e);
        vec_t v;
        v.i = i;
        v.e = out_t'(e);
        tbl.push_back(v);
    endtask

    initial begin
        in_t i;
        drive('0);
        reset = 1'b1;

        // Reset holds every output low even with a branch and load present.
        i = '0; i.rst = 1'b1; i.pcsrc = 1'b1; i.rsrc = 2'b01; i.rde = 5'd2; i.rs1d = 5'd2;
        i.rwm = 1'b1; i.rdm = 5'd4; i.rs1e = 5'd4;
        step(i, O_NONE, "reset_state");

        // ---------------- single-cycle vector table ----------------
        i = '0; i.rsrc = 2'b01; i.rde = 5'd5; i.rs1d = 5'd5;
        add(i, O_LW);                                            // load-use x5
        i = '0; i.rwm = 1'b1; i.rdm = 5'd5; i.rs1e = 5'd5;
        add(i, 12'b000000_10_00_00);                             // then forward from M
        i = '0; i.rsrc = 2'b01; i.rde = 5'd5; i.fpde = 1'b1; i.rs1d = 5'd5;
        add(i, O_NONE);                                          // f5 load, x5 read
        i = '0; i.rsrc = 2'b01; i.rde = 5'd5; i.fpde = 1'b1; i.rs2d = 5'd5; i.fprs2d = 1'b1;
        add(i, O_LW);                                            // f5 load, f5 read on rs2
        i = '0; i.rwm = 1'b1; i.rww = 1'b1; i.rdm = 5'd3; i.rdw = 5'd3; i.rs1e = 5'd3;
        add(i, 12'b000000_10_00_00);                             // M beats W
        i = '0; i.rwm = 1'b1; i.rww = 1'b1; i.rs2e = 5'd0;
        add(i, O_NONE);                                          // x0 never forwards
        i = '0; i.rww = 1'b1; i.rdw = 5'd7; i.rs2e = 5'd7;
        add(i, 12'b000000_00_01_00);                             // W forward on B
        i = '0; i.rwm = 1'b1; i.fpdm = 1'b1; i.fprs1e = 1'b1;
        add(i, 12'b000000_10_00_00);                             // f0 forwards
        i = '0; i.rwm = 1'b1; i.rdm = 5'd4; i.fpdm = 1'b1; i.rww = 1'b1; i.rdw = 5'd4; i.rs1e = 5'd4;
        add(i, 12'b000000_01_00_00);                             // M class differs, W matches
        i = '0; i.rdm = 5'd6; i.rdw = 5'd6; i.rs2e = 5'd6;
        add(i, O_NONE);                                          // no write enables
        i = '0; i.rwm = 1'b1; i.rdm = 5'd8; i.rs1e = 5'd8; i.rs2e = 5'd8;
        add(i, 12'b000000_10_10_00);                             // both operands from M
        i = '0; i.pcsrc = 1'b1;
        add(i, 12'b000110_00_00_00);                             // taken branch
        i = '0; i.rsrc = 2'b01; i.rde = 5'd0; i.rs1d = 5'd0;
        add(i, O_NONE);                                          // load to x0
        i = '0; i.rsrc = 2'b10; i.rde = 5'd9; i.rs1d = 5'd9;
        add(i, O_NONE);                                          // non-load result
        i = '0; i.rsrc = 2'b01; i.rde = 5'd9; i.rs2d = 5'd9; i.pcsrc = 1'b1;
        add(i, 12'b110110_00_00_00);                             // load-use with branch

        foreach (tbl[k]) step(tbl[k].i, tbl[k].e, $sformatf("tbl%0d", k));

        // ---------------- FP_LAT=4 sequencing, back to back ----------------
        i = '0; i.rst = 1'b1;
        step(i, O_NONE, "fp_reset");
        i = '0; i.fpalu = 1'b1;
        step(i, O_FP_ID, "fp1_c0");
        step(i, O_FP_BZ, "fp1_c1");
        step(i, O_FP_BZ, "fp1_c2");
        step(i, O_FP_DN, "fp1_done");                            // StallCount = 3 here
        step(i, O_FP_ID, "fp2_c0");
        i.rsrc = 2'b01; i.rde = 5'd5; i.rs1d = 5'd5; i.pcsrc = 1'b1;
        step(i, 12'b111101_00_00_10, "fp2_c1_prio");             // fp stall suppresses FlushE
        i = '0; i.fpalu = 1'b1;
        step(i, O_FP_BZ, "fp2_c2");
        step(i, O_FP_DN, "fp2_done");
        i = '0;
        step(i, O_NONE, "fp_idle");

        // ---------------- reset in the second BUSY cycle ----------------
        i = '0; i.fpalu = 1'b1;
        step(i, O_FP_ID, "abort_c0");
        step(i, O_FP_BZ, "abort_c1");
        i.rst = 1'b1;
        step(i, O_NONE, "abort_reset");
        i.rst = 1'b0;
        step(i, O_FP_ID, "restart_c0");                          // back in IDLE
        step(i, O_FP_BZ, "restart_c1");
        step(i, O_FP_BZ, "restart_c2");
        step(i, O_FP_DN, "restart_done");
        i = '0;
        step(i, O_NONE, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage integer/FP core. Drives stall, flush and forwarding controls for the IF/ID, ID/EX and EX/MEM stage registers. Resolves load-use and control hazards across both register files (integer x0–x31, FP f0–f31). Holds the execute stage for the full latency of multi-cycle FP ALU operations.

## Interface
- FP_LAT, 4, total execute-stage cycles of an FP ALU op; legal 1..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source register numbers of the instruction in decode.
- FPRs1D, FPRs2D  in  1 each  decode source register class (1 = FP file).
- Rs1E, Rs2E  in  5 each  source register numbers in execute.
- FPRs1E, FPRs2E  in  1 each  execute source register class.
- RdE, RdM, RdW  in  5 each  destination register numbers in execute, memory and writeback.
- FPDestE, FPDestM, FPDestW  in  1 each  destination register class.
- RegWriteM, RegWriteW  in  1 each  destination write enables.
- ResultSrcE  in  2  execute result select; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in execute.
- FPAluE  in  1  execute holds an FP ALU op.
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX respectively.
- FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM to a bubble.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = register file, 10 = memory-stage result, 01 = writeback result.
- FPBusy  out  1  FP sequencer is in BUSY.
- FPDone  out  1  final execute cycle of a multi-cycle FP op.
- StallCount  out  16  saturating count of cycles with StallF=1.

## Operation
- Match(rs, fprs, rd, fprd) = (rs == rd) && (fprs == fprd) && (fprd || rd != 0).
  - Integer x0 never matches.
  - FP f0 is a real register and does match.
- Forwarding (combinational), evaluated per E source:
  - Memory stage first: 10 if RegWriteM && Match(RsE, FPRsE, RdM, FPDestM).
  - Else writeback: 01 if RegWriteW && Match(RsE, FPRsE, RdW, FPDestW).
  - Else 00.
- lwStall = (ResultSrcE == 2'b01) && (Match(Rs1D, FPRs1D, RdE, FPDestE) || Match(Rs2D, FPRs2D, RdE, FPDestE)).
- FP sequencer has states IDLE and BUSY and a 4-bit elapsed counter cnt.
  - IDLE with FPAluE and FP_LAT > 1: fpStall = 1, next state BUSY, cnt <= 1.
  - BUSY with cnt == FP_LAT-1: fpStall = 0, FPDone = 1, next state IDLE, cnt <= 0.
  - BUSY otherwise: fpStall = 1, cnt <= cnt+1.
  - FP_LAT == 1: the FSM never leaves IDLE; FPDone = FPAluE in IDLE.
- Stall and flush outputs:
  - StallF = StallD = lwStall | fpStall.
  - StallE = FlushM = fpStall.
  - FlushD = PCSrcE.
  - FlushE = (lwStall | PCSrcE) & ~fpStall.
- Simultaneous events:
  - Load, FP op and branch in E are mutually exclusive by construction, so lwStall, fpStall and PCSrcE never coincide.
  - If they do, fpStall wins and FlushE is suppressed.
- StallCount increments on every clock edge with StallF=1 and saturates at 16'hFFFF.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
- FP op entering E at edge N:
  - Stalls are asserted for cycles N..N+FP_LAT-2.
  - FPDone is asserted in cycle N+FP_LAT-1.
  - The op advances to M at edge N+FP_LAT.
- Back-to-back FP ops restart from IDLE with no idle cycle between them.
- While reset is asserted:
  - All outputs are 0; ForwardAE and ForwardBE are 00.
  - State is IDLE, cnt = 0, StallCount = 0.
- Reset asserted mid-BUSY aborts the sequence immediately.

## Test plan
- Load into x5 in E, add reading x5 in D -> StallF=StallD=FlushE=1 for one cycle; the next cycle gives ForwardAE=10.
- Load into f5 in E, integer add reading x5 in D -> no stall, because the register classes differ.
- RdM=RdW=3 with RegWriteM=RegWriteW=1, Rs1E=3 -> ForwardAE=10; RdM=0 integer with Rs2E=0 -> ForwardBE=00.
- FP_LAT=4, fadd in E -> StallE=FlushM=1 for 3 cycles, FPDone=1 on the 4th, StallCount=3; then a second fadd in the following cycle repeats the pattern.
- PCSrcE=1 -> FlushD=FlushE=1, no stall.
- Reset asserted in the 2nd BUSY cycle -> all outputs 0 and FPBusy=0 immediately; after reset is released, state is IDLE.
